// File: rtl/pipe_share_arbiter_if.sv
// Handshake bundle between requesters, the shared datapath unit and the arbiter.
// The arbiter connects through the slave modport and the requester side through master.
interface pipe_share_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned SIZE  = 8
);
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ*SIZE-1:0] req_data;
  logic [N_REQ-1:0]      req_ready;
  logic                  hold;
  logic [SIZE-1:0]       unit_in_data;
  logic                  unit_in_valid;
  logic [SIZE-1:0]       unit_out_data;
  logic [N_REQ-1:0]      resp_valid;
  logic [SIZE-1:0]       resp_data;
  logic                  busy;

  modport master (
    output req_valid, req_data, hold, unit_out_data,
    input  req_ready, unit_in_data, unit_in_valid, resp_valid, resp_data, busy
  );

  modport slave (
    input  req_valid, req_data, hold, unit_out_data,
    output req_ready, unit_in_data, unit_in_valid, resp_valid, resp_data, busy
  );
endinterface

// File: rtl/pipe_share_arbiter.sv
// Round-robin sharing of one fixed-latency, non-reset pipelined unit among N_REQ
// requesters; a reset tag/valid shadow pipe routes each result back to its owner.
module pipe_share_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned SIZE    = 8,
  parameter int unsigned LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  pipe_share_arbiter_if.slave   bus
);
  localparam int unsigned IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [SIZE-1:0] unit_in_data_q, unit_in_data_d;
  // Stage 0 is the issue stage (aligned with unit_in_data); stages 1..LATENCY
  // track the unit's internal stages, so the last one lines up with unit_out_data.
  tag_t            tag_q [LATENCY+1];
  tag_t            tag_d [LATENCY+1];

  logic [SIZE-1:0] req_op [N_REQ];
  logic            grant_vld;
  logic [IDW-1:0]  grant_id;
  int unsigned     search_idx;

  for (genvar g = 0; g < N_REQ; g++) begin : g_op
    assign req_op[g] = bus.req_data[g*SIZE +: SIZE];
  end

  always_comb begin
    grant_vld  = 1'b0;
    grant_id   = '0;
    search_idx = 0;
    if (!rst && !bus.hold) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        search_idx = (32'(rr_ptr_q) + k) % N_REQ;
        if (!grant_vld && bus.req_valid[search_idx]) begin
          grant_vld = 1'b1;
          grant_id  = IDW'(search_idx);
        end
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (grant_vld) bus.req_ready[grant_id] = 1'b1;
  end

  // A grant is only raised for an asserted req_valid, so grant_vld is the transfer.
  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    unit_in_data_d = unit_in_data_q;
    tag_d[0]       = '{vld: grant_vld, id: grant_id};
    if (grant_vld) begin
      rr_ptr_d       = (32'(grant_id) == N_REQ - 1) ? '0 : grant_id + 1'b1;
      unit_in_data_d = req_op[grant_id];
    end
    for (int unsigned k = 1; k <= LATENCY; k++) begin
      tag_d[k] = tag_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q       <= '0;
      unit_in_data_q <= '0;
      for (int unsigned k = 0; k <= LATENCY; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      unit_in_data_q <= unit_in_data_d;
      for (int unsigned k = 0; k <= LATENCY; k++) begin
        tag_q[k] <= tag_d[k];
      end
    end
  end

  assign bus.unit_in_data  = unit_in_data_q;
  assign bus.unit_in_valid = tag_q[0].vld;
  assign bus.resp_data     = bus.unit_out_data;

  always_comb begin
    bus.resp_valid = '0;
    if (tag_q[LATENCY].vld) bus.resp_valid[tag_q[LATENCY].id] = 1'b1;
  end

  always_comb begin
    bus.busy = 1'b0;
    for (int unsigned k = 0; k <= LATENCY; k++) begin
      bus.busy = bus.busy | tag_q[k].vld;
    end
  end
endmodule

// File: tb/tb_pipe_share_arbiter.sv
// Directed bench for pipe_share_arbiter: a per-cycle vector table plus hand
// sequences for asynchronous reset and reset with operations in flight.
module tb_pipe_share_arbiter;
  localparam int unsigned N   = 4;
  localparam int unsigned W   = 8;
  localparam int unsigned LAT = 3;
  localparam int unsigned NV  = 34;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  pipe_share_arbiter_if #(.N_REQ(N), .SIZE(W)) bus ();

  pipe_share_arbiter #(.N_REQ(N), .SIZE(W), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Model of the shared unit: plain delay line, never reset, seeded with garbage.
  logic [W-1:0] upipe [LAT] = '{8'hEE, 8'hEE, 8'hEE};
  always @(posedge clk) begin
    upipe[0] <= bus.unit_in_data;
    for (int i = 1; i < LAT; i++) upipe[i] <= upipe[i-1];
  end
  assign bus.unit_out_data = upipe[LAT-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]   rv;
    logic [N*W-1:0] rd;
    logic           hold;
    logic [N-1:0]   ready;
    logic           uiv;
    logic [W-1:0]   ud;
    logic [N-1:0]   resp;
    logic [W-1:0]   rdata;
    logic           busy;
  } vec_t;

  vec_t vt [NV];

  function automatic vec_t v(input logic [N-1:0] rv, input logic [N*W-1:0] rd, input logic hold,
                             input logic [N-1:0] ready, input logic uiv, input logic [W-1:0] ud,
                             input logic [N-1:0] resp, input logic [W-1:0] rdata, input logic busy);
    vec_t r;
    r.rv = rv; r.rd = rd; r.hold = hold; r.ready = ready; r.uiv = uiv;
    r.ud = ud; r.resp = resp; r.rdata = rdata; r.busy = busy;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  localparam logic [31:0] RR = 32'h1312_1110;
  localparam logic [31:0] SW = 32'h3300_0030;
  localparam logic [31:0] HD = 32'h4342_4140;

  initial begin
    // Round robin from pointer 0
    vt[0]  = v(4'hF, RR, 0, 4'h1, 0, 8'h00, 4'h0, 8'h00, 0);
    vt[1]  = v(4'hF, RR, 0, 4'h2, 1, 8'h10, 4'h0, 8'h00, 1);
    vt[2]  = v(4'hF, RR, 0, 4'h4, 1, 8'h11, 4'h0, 8'h00, 1);
    vt[3]  = v(4'hF, RR, 0, 4'h8, 1, 8'h12, 4'h0, 8'h00, 1);
    vt[4]  = v(4'hF, RR, 0, 4'h1, 1, 8'h13, 4'h1, 8'h10, 1);
    vt[5]  = v(4'h0, '0, 0, 4'h0, 1, 8'h10, 4'h2, 8'h11, 1);
    vt[6]  = v(4'h0, '0, 0, 4'h0, 0, 8'h00, 4'h4, 8'h12, 1);
    vt[7]  = v(4'h0, '0, 0, 4'h0, 0, 8'h00, 4'h8, 8'h13, 1);
    vt[8]  = v(4'h0, '0, 0, 4'h0, 0, 8'h00, 4'h1, 8'h10, 1);
    vt[9]  = v(4'h0, '0, 0, 4'h0, 0, 8'h00, 4'h0, 8'h00, 0);
    // Single request from requester 2 (pointer 1 -> 3)
    vt[10] = v(4'h4, 32'h005A_0000, 0, 4'h4, 0, 8'h00, 4'h0, 8'h00, 0);
    vt[11] = v(4'h0, '0, 0, 4'h0, 1, 8'h5A, 4'h0, 8'h00, 1);
    vt[12] = v(4'h0, '0, 0, 4'h0, 0, 8'h00, 4'h0, 8'h00, 1);
    vt[13] = v(4'h0, '0, 0, 4'h0, 0, 8'h00, 4'h0, 8'h00, 1);
    vt[14] = v(4'h0, '0, 0, 4'h0, 0, 8'h00, 4'h4, 8'h5A, 1);
    // Pointer wrap: 3 then 0
    vt[15] = v(4'h9, SW, 0, 4'h8, 0, 8'h00, 4'h0, 8'h00, 0);
    vt[16] = v(4'h9, SW, 0, 4'h1, 1, 8'h33, 4'h0, 8'h00, 1);
    vt[17] = v(4'h0, '0, 0, 4'h0, 1, 8'h30, 4'h0, 8'h00, 1);
    vt[18] = v(4'h0, '0, 0, 4'h0, 0, 8'h00, 4'h0, 8'h00, 1);
    vt[19] = v(4'h0, '0, 0, 4'h0, 0, 8'h00, 4'h8, 8'h33, 1);
    vt[20] = v(4'h0, '0, 0, 4'h0, 0, 8'h00, 4'h1, 8'h30, 1);
    vt[21] = v(4'h0, '0, 0, 4'h0, 0, 8'h00, 4'h0, 8'h00, 0);
    // Hold for three cycles with all four requesting (pointer 1)
    vt[22] = v(4'hF, HD, 0, 4'h2, 0, 8'h00, 4'h0, 8'h00, 0);
    vt[23] = v(4'hF, HD, 0, 4'h4, 1, 8'h41, 4'h0, 8'h00, 1);
    vt[24] = v(4'hF, HD, 1, 4'h0, 1, 8'h42, 4'h0, 8'h00, 1);
    vt[25] = v(4'hF, HD, 1, 4'h0, 0, 8'h00, 4'h0, 8'h00, 1);
    vt[26] = v(4'hF, HD, 1, 4'h0, 0, 8'h00, 4'h2, 8'h41, 1);
    vt[27] = v(4'hF, HD, 0, 4'h8, 0, 8'h00, 4'h4, 8'h42, 1);
    vt[28] = v(4'hF, HD, 0, 4'h1, 1, 8'h43, 4'h0, 8'h00, 1);
    vt[29] = v(4'h0, '0, 0, 4'h0, 1, 8'h40, 4'h0, 8'h00, 1);
    vt[30] = v(4'h0, '0, 0, 4'h0, 0, 8'h00, 4'h0, 8'h00, 1);
    vt[31] = v(4'h0, '0, 0, 4'h0, 0, 8'h00, 4'h8, 8'h43, 1);
    vt[32] = v(4'h0, '0, 0, 4'h0, 0, 8'h00, 4'h1, 8'h40, 1);
    vt[33] = v(4'h0, '0, 0, 4'h0, 0, 8'h00, 4'h0, 8'h00, 0);

    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.hold      = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset mid-cycle clears outputs without a clock edge
    @(negedge clk);
    bus.req_valid = 4'h1;
    bus.req_data  = 32'h0000_0001;
    #1;
    chk("pre_rst ready", 32'(bus.req_ready), 32'h1);
    @(posedge clk);
    #3;
    chk("pre_rst uiv", 32'(bus.unit_in_valid), 32'h1);
    chk("pre_rst busy", 32'(bus.busy), 32'h1);
    rst = 1'b1;
    #1;
    chk("async_rst ready", 32'(bus.req_ready), 32'h0);
    chk("async_rst uiv", 32'(bus.unit_in_valid), 32'h0);
    chk("async_rst busy", 32'(bus.busy), 32'h0);
    chk("async_rst resp", 32'(bus.resp_valid), 32'h0);
    chk("async_rst uid", 32'(bus.unit_in_data), 32'h0);
    @(negedge clk);
    bus.req_valid = '0;
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      bus.req_valid = vt[i].rv;
      bus.req_data  = vt[i].rd;
      bus.hold      = vt[i].hold;
      #1;
      chk($sformatf("v%0d ready", i), 32'(bus.req_ready), 32'(vt[i].ready));
      chk($sformatf("v%0d uiv", i), 32'(bus.unit_in_valid), 32'(vt[i].uiv));
      if (vt[i].uiv) chk($sformatf("v%0d uid", i), 32'(bus.unit_in_data), 32'(vt[i].ud));
      chk($sformatf("v%0d resp", i), 32'(bus.resp_valid), 32'(vt[i].resp));
      if (vt[i].resp != '0) chk($sformatf("v%0d rdata", i), 32'(bus.resp_data), 32'(vt[i].rdata));
      chk($sformatf("v%0d busy", i), 32'(bus.busy), 32'(vt[i].busy));
    end

    // Reset with two ops in flight (pointer starts at 1)
    @(negedge clk);
    bus.req_valid = 4'h1;
    bus.req_data  = 32'h0000_0061;
    bus.hold      = 1'b0;
    #1;
    chk("mf c0 ready", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    bus.req_valid = 4'h2;
    bus.req_data  = 32'h0000_6200;
    #1;
    chk("mf c1 ready", 32'(bus.req_ready), 32'h2);
    chk("mf c1 uiv", 32'(bus.unit_in_valid), 32'h1);
    @(negedge clk);
    bus.req_valid = '0;
    rst = 1'b1;
    #1;
    chk("mf c2 busy", 32'(bus.busy), 32'h0);
    chk("mf c2 uiv", 32'(bus.unit_in_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 3; k <= 6; k++) begin
      if (k > 3) @(negedge clk);
      #1;
      chk($sformatf("mf c%0d resp", k), 32'(bus.resp_valid), 32'h0);
      chk($sformatf("mf c%0d busy", k), 32'(bus.busy), 32'h0);
    end
    // Pointer must be back at 0: requesters 1 and 2 pending -> 1 wins
    @(negedge clk);
    bus.req_valid = 4'h6;
    bus.req_data  = 32'h0000_7700;
    #1;
    chk("mf c7 ready", 32'(bus.req_ready), 32'h2);
    for (int k = 8; k <= 12; k++) begin
      @(negedge clk);
      bus.req_valid = '0;
      #1;
      if (k == 8) chk("mf c8 uid", 32'(bus.unit_in_data), 32'h77);
      chk($sformatf("mf c%0d resp", k), 32'(bus.resp_valid), (k == 11) ? 32'h2 : 32'h0);
      if (k == 11) chk("mf c11 rdata", 32'(bus.resp_data), 32'h77);
      chk($sformatf("mf c%0d busy", k), 32'(bus.busy), (k <= 11) ? 32'h1 : 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_share_arbiter.md
Name: pipe_share_arbiter

Overview:
- Shares one fixed-latency pipelined datapath unit among N_REQ requesters. The unit is a free-running SIZE-bit delay pipeline with LATENCY stages.
- Arbitration is round-robin with a valid/ready handshake. Each accepted operand is issued to the unit on the next cycle.
- A tag/valid shadow pipeline tracks each in-flight operation, so each result returns to its owner after exactly LATENCY cycles.
- The shadow pipeline supplies validity the unit itself lacks: the unit's internal stages are not reset.

Parameters:
- N_REQ, 4, number of requesters (>=2).
- SIZE, 8, operand/result width in bits.
- LATENCY, 3, unit latency in cycles from unit_in_data to unit_out_data (>=1).

Ports:
- clk, input, 1, clock; all state on rising edge.
- rst, input, 1, asynchronous active-high reset.
- req_valid, input, N_REQ, per-requester request.
- req_data, input, N_REQ*SIZE, operands; requester i occupies bits [i*SIZE +: SIZE].
- req_ready, output, N_REQ, one-hot grant (combinational); transfer when req_valid[i] && req_ready[i].
- hold, input, 1, blocks new grants; in-flight ops still complete.
- unit_in_data, output, SIZE, registered operand to the datapath unit.
- unit_in_valid, output, 1, registered; high when unit_in_data carries an issued op.
- unit_out_data, input, SIZE, datapath unit output.
- resp_valid, output, N_REQ, one-hot result strobe (registered tag pipe, no combinational path from inputs).
- resp_data, output, SIZE, equals unit_out_data (passthrough); meaningful only when resp_valid != 0.
- busy, output, 1, high while any op is issued but not yet responded.

Behaviour:
- Reset (async, rst=1): rr_ptr=0, unit_in_valid=0, unit_in_data=0, tag pipe all invalid, resp_valid=0, busy=0. req_ready=0 while rst=1.
- Arbitration (combinational, cycle t):
  - If hold=0, grant the first i with req_valid[i]=1, searching from rr_ptr upward with wrap modulo N_REQ.
  - At most one grant per cycle. req_ready=0 when hold=1 or no request.
  - req_ready must not depend on req_data.
- Pointer update: on a transfer by requester g, rr_ptr <= (g+1) mod N_REQ. Otherwise rr_ptr holds.
- Issue (edge ending cycle t):
  - On transfer: unit_in_data <= req_data[g], unit_in_valid <= 1, tag stage 0 <= {valid=1, id=g}.
  - Otherwise: unit_in_valid <= 0, unit_in_data holds, tag stage 0 <= invalid.
- Tag pipe:
  - LATENCY stages of {valid, id[clog2(N_REQ)-1:0]}, advancing every cycle unconditionally.
  - hold does not stall it.
- Response:
  - The last tag stage drives resp_valid = valid ? (1<<id) : 0.
  - Accepted at edge t → operand on unit_in_data during t+1 → resp_valid[g]=1 during cycle t+1+LATENCY.
  - Responses appear in issue order, one per cycle at most.
- Throughput: one op per cycle sustained. Back-to-back grants to the same requester are allowed only when it is the sole requester.
- busy: high if unit_in_valid or any tag stage valid.
- Reset mid-operation:
  - All in-flight tags are discarded and no resp_valid pulses occur for them.
  - Garbage from the unreset unit stages is never flagged valid.
- hold asserted mid-stream: in-flight ops complete normally; busy falls LATENCY+1 cycles after the last issue.
- req_valid deasserted without a transfer: legal, no state change.

Test Plan:
- Reset: assert rst asynchronously mid-cycle → req_ready=0, resp_valid=0, busy=0, unit_in_valid=0 immediately, without waiting for a clock edge.
- Single request: req_valid=4'b0100, data[2]=8'h5A at cycle 0 → unit_in_valid=1 and unit_in_data=8'h5A at cycle 1; resp_valid=4'b0100 and resp_data=8'h5A at cycle 4 (LATENCY=3); busy high cycles 1–4.
- Round-robin:
  - Setup: all four req_valid held high, data[i]=8'h10+i.
  - Required grants: 0,1,2,3,0 on consecutive cycles.
  - Required responses: resp_valid 0001,0010,0100,1000,0001 on cycles 4–8 with data 10,11,12,13,10.
- Pointer wrap: rr_ptr=3 after a grant to requester 2; req_valid=4'b1001 → requester 3 granted, then requester 0.
- hold: four requests queued, hold=1 for cycles 2–4 → no req_ready in cycles 2–4; the two already-issued ops respond on cycles 4 and 5; granting resumes at cycle 5.
- Reset mid-flight: issue ops at cycles 0–1, pulse rst at cycle 2 → no resp_valid in cycles 3–6; a fresh request after reset returns correctly after LATENCY+1 cycles.
